// File: rtl/mips_multicycle_ctrl_if.sv
// Unified memory port between the multi-cycle controller (master) and memory (slave).
interface mips_multicycle_ctrl_if;
  logic mem_req;
  logic mem_we;
  logic iord;
  logic mem_ready;

  modport master (output mem_req, output mem_we, output iord, input mem_ready);
  modport slave  (input mem_req, input mem_we, input iord, output mem_ready);
endinterface

// File: rtl/mips_multicycle_ctrl.sv
// Multi-cycle MIPS control sequencer with memory timeout, halt and illegal-instruction traps.
// Optional performance counters are built when MIPS_CTRL_PERF_EN is defined.
module mips_multicycle_ctrl #(
  parameter int unsigned MEM_TIMEOUT = 16,
  parameter int unsigned CNT_W       = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  mips_multicycle_ctrl_if.master mem,
  input  logic [5:0]             opcode,
  input  logic [5:0]             funct,
  input  logic                   alu_zero,
  input  logic                   halt_req,
  output logic                   ir_write,
  output logic                   pc_en,
  output logic                   pc_source,
  output logic                   alu_src_a,
  output logic [1:0]             alu_src_b,
  output logic [1:0]             alu_control,
  output logic                   reg_dst,
  output logic                   mem_to_reg,
  output logic                   reg_write,
  output logic                   instr_done,
  output logic                   halted,
  output logic                   illegal_instr,
  output logic                   bus_error,
  output logic [CNT_W-1:0]       perf_cycles,
  output logic [CNT_W-1:0]       perf_retired
);
  localparam int unsigned    TW        = $clog2(MEM_TIMEOUT + 1);
  localparam logic [TW-1:0]  WAIT_LAST = TW'(MEM_TIMEOUT - 1);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] F_NOP    = 6'b000000;
  localparam logic [5:0] F_ADD    = 6'b100000;
  localparam logic [5:0] F_SUB    = 6'b100010;
  localparam logic [5:0] F_AND    = 6'b100100;

  typedef enum logic [3:0] {
    S_IDLE, S_FETCH, S_DECODE, S_MEM_ADDR, S_MEM_READ, S_MEM_WB, S_MEM_WRITE,
    S_R_EXEC, S_R_WB, S_ADDI_EXEC, S_ADDI_WB, S_BRANCH, S_TRAP
  } state_t;

  state_t        state, next, boundary;
  logic [TW-1:0] wait_cnt;
  logic          is_lw;
  logic [1:0]    r_alu, dec_alu;
  logic          r_legal, set_illegal, in_mem_state, timeout_hit;

  // Memory states are derived from state, not from mem_req, to keep the timeout free of comb loops.
  assign in_mem_state = (state == S_FETCH) || (state == S_MEM_READ) || (state == S_MEM_WRITE);
  assign timeout_hit  = in_mem_state && !mem.mem_ready && (wait_cnt == WAIT_LAST);
  assign r_legal      = (funct == F_ADD) || (funct == F_SUB) || (funct == F_AND);

  always_comb begin
    dec_alu = 2'b00;
    if (funct == F_SUB)      dec_alu = 2'b11;
    else if (funct == F_AND) dec_alu = 2'b01;
  end

  always_comb begin
    next          = state;
    boundary      = S_FETCH;
    mem.mem_req   = 1'b0;
    mem.mem_we    = 1'b0;
    mem.iord      = 1'b0;
    ir_write      = 1'b0;
    pc_en         = 1'b0;
    pc_source     = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = 2'b00;
    alu_control   = 2'b00;
    reg_dst       = 1'b0;
    mem_to_reg    = 1'b0;
    reg_write     = 1'b0;
    instr_done    = 1'b0;
    halted        = 1'b0;
    set_illegal   = 1'b0;
    if (halt_req) boundary = S_IDLE;

    case (state)
      S_IDLE: begin
        halted = 1'b1;
        if (!halt_req) next = S_FETCH;
      end
      S_FETCH: begin
        mem.mem_req = 1'b1;
        alu_src_b   = 2'b01;
        if (mem.mem_ready) begin
          ir_write = 1'b1;
          pc_en    = 1'b1;
          next     = S_DECODE;
        end
      end
      S_DECODE: begin
        alu_src_b = 2'b11;
        case (opcode)
          OP_RTYPE: begin
            if (funct == F_NOP) begin
              instr_done = 1'b1;
              next       = boundary;
            end else if (r_legal) begin
              next = S_R_EXEC;
            end else begin
              next        = S_TRAP;
              set_illegal = 1'b1;
            end
          end
          OP_LW, OP_SW: next = S_MEM_ADDR;
          OP_BEQ:       next = S_BRANCH;
          OP_ADDI:      next = S_ADDI_EXEC;
          default: begin
            next        = S_TRAP;
            set_illegal = 1'b1;
          end
        endcase
      end
      S_MEM_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        if (is_lw) next = S_MEM_READ;
        else       next = S_MEM_WRITE;
      end
      S_MEM_READ: begin
        mem.mem_req = 1'b1;
        mem.iord    = 1'b1;
        if (mem.mem_ready) next = S_MEM_WB;
      end
      S_MEM_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        instr_done = 1'b1;
        next       = boundary;
      end
      S_MEM_WRITE: begin
        mem.mem_req = 1'b1;
        mem.mem_we  = 1'b1;
        mem.iord    = 1'b1;
        if (mem.mem_ready) begin
          instr_done = 1'b1;
          next       = boundary;
        end
      end
      S_R_EXEC: begin
        alu_src_a   = 1'b1;
        alu_control = r_alu;
        next        = S_R_WB;
      end
      S_R_WB: begin
        reg_write   = 1'b1;
        reg_dst     = 1'b1;
        alu_control = r_alu;
        instr_done  = 1'b1;
        next        = boundary;
      end
      S_ADDI_EXEC: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        next      = S_ADDI_WB;
      end
      S_ADDI_WB: begin
        reg_write  = 1'b1;
        instr_done = 1'b1;
        next       = boundary;
      end
      S_BRANCH: begin
        alu_src_a   = 1'b1;
        alu_control = 2'b11;
        pc_source   = 1'b1;
        pc_en       = alu_zero;
        instr_done  = 1'b1;
        next        = boundary;
      end
      S_TRAP:  next = S_TRAP;
      default: next = S_IDLE;
    endcase

    if (timeout_hit) next = S_TRAP;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= S_IDLE;
      wait_cnt      <= '0;
      is_lw         <= 1'b0;
      r_alu         <= 2'b00;
      illegal_instr <= 1'b0;
      bus_error     <= 1'b0;
    end else begin
      state <= next;
      if (in_mem_state && !mem.mem_ready && !timeout_hit) wait_cnt <= wait_cnt + 1'b1;
      else                                                wait_cnt <= '0;
      // IR is only guaranteed valid in DECODE, so the later states work from these latches.
      if (state == S_DECODE) begin
        is_lw <= (opcode == OP_LW);
        r_alu <= dec_alu;
      end
      if (set_illegal) illegal_instr <= 1'b1;
      if (timeout_hit) bus_error     <= 1'b1;
    end
  end

`ifdef MIPS_CTRL_PERF_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      perf_cycles  <= '0;
      perf_retired <= '0;
    end else begin
      if (state != S_IDLE && state != S_TRAP) perf_cycles <= perf_cycles + 1'b1;
      if (instr_done)                         perf_retired <= perf_retired + 1'b1;
    end
  end
`else
  assign perf_cycles  = '0;
  assign perf_retired = '0;
`endif

endmodule
